// File: rtl/keccak_padder_multirate_if.sv
// Keccak padder bus: message word input, padded block output and
// control/status. The padder is the slave; whatever feeds and drains
// it is the master.
interface keccak_padder_multirate_if #(
  parameter int W        = 64,
  parameter int MAX_RATE = 1344
);
  logic                 i_start;
  logic [1:0]           i_mode;
  logic [W-1:0]         i_in;
  logic                 i_in_valid;
  logic                 i_in_last;
  logic [$clog2(W/8):0] i_byte_num;
  logic                 o_in_ready;
  logic [MAX_RATE-1:0]  o_out;
  logic                 o_out_valid;
  logic                 o_out_last;
  logic                 i_out_ack;
  logic                 o_done;

  modport slave (
    input  i_start, i_mode, i_in, i_in_valid, i_in_last, i_byte_num, i_out_ack,
    output o_in_ready, o_out, o_out_valid, o_out_last, o_done
  );

  modport master (
    output i_start, i_mode, i_in, i_in_valid, i_in_last, i_byte_num, i_out_ack,
    input  o_in_ready, o_out, o_out_valid, o_out_last, o_done
  );
endinterface

// File: rtl/keccak_padder_multirate.sv
// Keccak padder: packs W-bit message words into rate-sized blocks and
// applies pad10*1 with the FIPS-202 domain byte of the latched mode.
// Messages that end exactly on a block boundary get an extra block that
// holds only padding.
module keccak_padder_multirate #(
  parameter int         W        = 64,
  parameter int         MAX_RATE = 1344,
  parameter logic [7:0] DS_SHAKE = 8'h1F,
  parameter logic [7:0] DS_SHA3  = 8'h06
) (
  input logic                      clk,
  input logic                      reset,
  keccak_padder_multirate_if.slave bus
);
  localparam int WB = W / 8;
  localparam int CW = $clog2(MAX_RATE / W + 1);
  localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_PAD,
    S_HOLD,
    S_DONE
  } state_t;

  state_t              r_state, w_stateNext;
  logic [MAX_RATE-1:0] r_buf, w_bufNext;
  logic [CW-1:0]       r_cnt, w_cntNext;
  logic [1:0]          r_mode, w_modeNext;
  logic                r_outLast, w_outLastNext;
  logic                r_padPending, w_padPendingNext;
  logic                r_done, w_doneNext;

  int                  w_rate;
  int                  w_rw;
  int                  w_rb;
  int                  w_bn;
  logic [7:0]          w_ds;
  logic [W-1:0]        w_lastWord;

  // Rate (in words and bytes) and domain byte of the latched mode
  always_comb begin
    case (r_mode)
      2'b00:   w_rate = 1344;
      2'b01:   w_rate = 1088;
      2'b10:   w_rate = 1088;
      default: w_rate = 576;
    endcase
    w_rw = w_rate / W;
    w_rb = w_rate / 8;
    w_ds = r_mode[1] ? DS_SHA3 : DS_SHAKE;
  end

  // Partial final word: keep the valid bytes, place the domain byte right after them
  always_comb begin
    w_bn       = (int'(bus.i_byte_num) > WB) ? WB : int'(bus.i_byte_num);
    w_lastWord = '0;
    for (int k = 0; k < WB; k++) begin
      if (k < w_bn) begin
        w_lastWord[8*k +: 8] = bus.i_in[8*k +: 8];
      end else if (k == w_bn) begin
        w_lastWord[8*k +: 8] = w_ds;
      end
    end
  end

  // Next state and next block contents; the 0x80 is OR-ed last so it merges with DS when they share a byte
  always_comb begin
    w_stateNext      = r_state;
    w_bufNext        = r_buf;
    w_cntNext        = r_cnt;
    w_modeNext       = r_mode;
    w_outLastNext    = r_outLast;
    w_padPendingNext = r_padPending;
    w_doneNext       = r_done;

    case (r_state)
      S_IDLE, S_DONE: begin
        if (bus.i_start) begin
          w_stateNext      = S_FILL;
          w_bufNext        = '0;
          w_cntNext        = '0;
          w_modeNext       = bus.i_mode;
          w_outLastNext    = 1'b0;
          w_padPendingNext = 1'b0;
          w_doneNext       = 1'b0;
        end
      end

      S_FILL: begin
        if (bus.i_in_valid) begin
          if (!bus.i_in_last) begin
            w_bufNext[W*int'(r_cnt) +: W] = bus.i_in;
            w_cntNext = r_cnt + CNT_ONE;
            if (int'(r_cnt) + 1 == w_rw) begin
              w_stateNext   = S_HOLD;
              w_outLastNext = 1'b0;
            end
          end else if (w_bn < WB) begin
            w_bufNext[W*int'(r_cnt) +: W] = w_lastWord;
            w_bufNext[8*(w_rb-1) +: 8]    = w_bufNext[8*(w_rb-1) +: 8] | 8'h80;
            w_stateNext   = S_HOLD;
            w_outLastNext = 1'b1;
          end else if (int'(r_cnt) < w_rw - 1) begin
            w_bufNext[W*int'(r_cnt) +: W]     = bus.i_in;
            w_bufNext[W*(int'(r_cnt)+1) +: 8] = w_ds;
            w_bufNext[8*(w_rb-1) +: 8]        = w_bufNext[8*(w_rb-1) +: 8] | 8'h80;
            w_stateNext   = S_HOLD;
            w_outLastNext = 1'b1;
          end else begin
            w_bufNext[W*int'(r_cnt) +: W] = bus.i_in;
            w_cntNext        = r_cnt + CNT_ONE;
            w_stateNext      = S_HOLD;
            w_outLastNext    = 1'b0;
            w_padPendingNext = 1'b1;
          end
        end
      end

      S_PAD: begin
        w_bufNext[7:0]             = w_ds;
        w_bufNext[8*(w_rb-1) +: 8] = w_bufNext[8*(w_rb-1) +: 8] | 8'h80;
        w_padPendingNext = 1'b0;
        w_outLastNext    = 1'b1;
        w_stateNext      = S_HOLD;
      end

      S_HOLD: begin
        if (bus.i_out_ack) begin
          w_bufNext     = '0;
          w_cntNext     = '0;
          w_outLastNext = 1'b0;
          if (r_outLast) begin
            w_stateNext = S_DONE;
            w_doneNext  = 1'b1;
          end else if (r_padPending) begin
            w_stateNext = S_PAD;
          end else begin
            w_stateNext = S_FILL;
          end
        end
      end

      default: begin
        w_stateNext = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset clears everything at once
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_buf        <= '0;
      r_cnt        <= '0;
      r_mode       <= 2'b00;
      r_outLast    <= 1'b0;
      r_padPending <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state      <= w_stateNext;
      r_buf        <= w_bufNext;
      r_cnt        <= w_cntNext;
      r_mode       <= w_modeNext;
      r_outLast    <= w_outLastNext;
      r_padPending <= w_padPendingNext;
      r_done       <= w_doneNext;
    end
  end

  assign bus.o_out       = r_buf;
  assign bus.o_out_valid = (r_state == S_HOLD);
  assign bus.o_in_ready  = (r_state == S_FILL);
  assign bus.o_out_last  = r_outLast;
  assign bus.o_done      = r_done;
endmodule

// File: tb/tb_keccak_padder_multirate.sv
// Directed bench for the Keccak padder: expected blocks are built by hand
// from the pad10*1 rules, queued when a message is driven and compared
// word by word when the padder presents each block.
module tb_keccak_padder_multirate;
  localparam int W  = 64;
  localparam int MR = 1344;

  typedef struct {
    logic [MR-1:0] data;
    logic          last;
  } blk_t;

  logic          clk = 1'b0;
  logic          reset;
  int            testsRun = 0;
  int            failCount = 0;
  blk_t          sb[$];
  blk_t          e;
  logic [MR-1:0] lastExp;
  logic [63:0]   words[21];
  logic [63:0]   xWord;
  logic [63:0]   v;

  keccak_padder_multirate_if #(.W(W), .MAX_RATE(MR)) bus ();

  keccak_padder_multirate #(
    .W(W), .MAX_RATE(MR), .DS_SHAKE(8'h1F), .DS_SHA3(8'h06)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  // Free-running clock, 10 time units per cycle
  always #5 clk = ~clk;

  task automatic checkValue(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic startMessage(input logic [1:0] m);
    bus.i_mode  = m;
    bus.i_start = 1'b1;
    @(posedge clk); #1;
    bus.i_start = 1'b0;
  endtask

  task automatic applyStimulus(input logic [63:0] data, input logic last,
                               input logic [3:0] bn, input string tag);
    int n = 0;
    bus.i_in       = data;
    bus.i_in_valid = 1'b1;
    bus.i_in_last  = last;
    bus.i_byte_num = bn;
    @(negedge clk);
    while (bus.o_in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkValue({tag, ".accept"}, 64'(bus.o_in_ready), 64'd1);
    if (bus.o_in_ready === 1'b1) begin
      @(posedge clk); #1;
    end
    bus.i_in_valid = 1'b0;
    bus.i_in_last  = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input bit doAck);
    int   n = 0;
    blk_t x;
    @(negedge clk);
    while (bus.o_out_valid !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkValue({tag, ".valid"}, 64'(bus.o_out_valid), 64'd1);
    checkValue({tag, ".sb"}, 64'(sb.size() > 0), 64'd1);
    x.data = '0;
    x.last = 1'b0;
    if (sb.size() > 0) x = sb.pop_front();
    lastExp = x.data;
    for (int j = 0; j < MR / 64; j++) begin
      checkValue($sformatf("%s.w%0d", tag, j), bus.o_out[64*j +: 64], x.data[64*j +: 64]);
    end
    checkValue({tag, ".last"}, 64'(bus.o_out_last), 64'(x.last));
    if (doAck) begin
      bus.i_out_ack = 1'b1;
      @(posedge clk); #1;
      bus.i_out_ack = 1'b0;
    end
  endtask

  initial begin
    reset          = 1'b1;
    bus.i_start    = 1'b0;
    bus.i_mode     = 2'b00;
    bus.i_in       = '0;
    bus.i_in_valid = 1'b0;
    bus.i_in_last  = 1'b0;
    bus.i_byte_num = '0;
    bus.i_out_ack  = 1'b0;

    // Reset values
    #3;
    checkValue("rst.out_valid", 64'(bus.o_out_valid), 64'd0);
    checkValue("rst.in_ready", 64'(bus.o_in_ready), 64'd0);
    checkValue("rst.out_last", 64'(bus.o_out_last), 64'd0);
    checkValue("rst.done", 64'(bus.o_done), 64'd0);
    checkValue("rst.out_any", 64'(|bus.o_out), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;

    // 1: SHA3-512 empty message; input data must be masked away
    startMessage(2'b11);
    e.data = '0; e.data[7:0] = 8'h06; e.data[575:568] = 8'h80; e.last = 1'b1;
    sb.push_back(e);
    applyStimulus(64'hDEAD_BEEF_CAFE_F00D, 1'b1, 4'd0, "t1");
    checkValue("t1.latency", 64'(bus.o_out_valid), 64'd1);
    checkOutput("t1", 1'b1);
    @(negedge clk);
    checkValue("t1.done", 64'(bus.o_done), 64'd1);
    checkValue("t1.idleReady", 64'(bus.o_in_ready), 64'd0);

    // 2: SHAKE128 block-aligned message needs an extra padding block
    startMessage(2'b00);
    checkValue("t2.doneClr", 64'(bus.o_done), 64'd0);
    e.data = '0; e.last = 1'b0;
    for (int i = 0; i < 21; i++) begin
      words[i] = {$urandom(), $urandom()};
      e.data[64*i +: 64] = words[i];
    end
    sb.push_back(e);
    e.data = '0; e.data[7:0] = 8'h1F; e.data[1343:1336] = 8'h80; e.last = 1'b1;
    sb.push_back(e);
    for (int i = 0; i < 21; i++) applyStimulus(words[i], (i == 20), 4'd8, "t2");
    checkOutput("t2.b1", 1'b1);
    checkValue("t2.padGap", 64'(bus.o_out_valid), 64'd0);
    checkOutput("t2.b2", 1'b1);

    // 3: SHA3-512 DS and 0x80 collide in the final byte; mode change after start ignored
    startMessage(2'b11);
    bus.i_mode = 2'b00;
    e.data = '0; e.last = 1'b1;
    for (int i = 0; i < 9; i++) begin
      words[i] = {$urandom(), $urandom()};
      if (i < 8) e.data[64*i +: 64] = words[i];
    end
    e.data[64*8 +: 56] = words[8][55:0];
    e.data[575:568]    = 8'h86;
    sb.push_back(e);
    for (int i = 0; i < 9; i++) applyStimulus(words[i], (i == 8), (i == 8) ? 4'd7 : 4'd8, "t3");
    checkOutput("t3", 1'b1);

    // 4: SHAKE256 partial final word of 3 bytes
    startMessage(2'b01);
    e.data = '0; e.data[23:0] = 24'hFFFFFF; e.data[31:24] = 8'h1F;
    e.data[1087:1080] = 8'h80; e.last = 1'b1;
    sb.push_back(e);
    applyStimulus(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 4'd3, "t4");
    checkOutput("t4", 1'b1);

    // 5: backpressure on a full non-last block, plus an ignored mid-message start
    startMessage(2'b11);
    e.data = '0; e.last = 1'b0;
    for (int i = 0; i < 9; i++) begin
      words[i] = {$urandom(), $urandom()};
      e.data[64*i +: 64] = words[i];
    end
    sb.push_back(e);
    xWord = 64'h0123_4567_89AB_CDEF;
    e.data = '0; e.data[63:0] = xWord; e.data[71:64] = 8'h06;
    e.data[575:568] = 8'h80; e.last = 1'b1;
    sb.push_back(e);
    for (int i = 0; i < 4; i++) applyStimulus(words[i], 1'b0, 4'd8, "t5");
    startMessage(2'b00);
    checkValue("t5.startIgnored", 64'(bus.o_in_ready), 64'd1);
    for (int i = 4; i < 9; i++) applyStimulus(words[i], 1'b0, 4'd8, "t5");
    checkOutput("t5.b1", 1'b0);
    bus.i_in       = xWord;
    bus.i_in_valid = 1'b1;
    bus.i_in_last  = 1'b0;
    bus.i_byte_num = 4'd8;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checkValue("t5.holdValid", 64'(bus.o_out_valid), 64'd1);
      checkValue("t5.holdReady", 64'(bus.o_in_ready), 64'd0);
      checkValue("t5.stable", 64'(|(bus.o_out ^ lastExp)), 64'd0);
    end
    bus.i_out_ack = 1'b1;
    @(posedge clk); #1;
    bus.i_out_ack = 1'b0;
    applyStimulus(xWord, 1'b0, 4'd8, "t5");
    applyStimulus({$urandom(), $urandom()}, 1'b1, 4'd0, "t5");
    checkOutput("t5.b2", 1'b1);

    // 6: reset mid-fill aborts, then a fresh SHA3-256 one-word message
    startMessage(2'b10);
    for (int i = 0; i < 5; i++) applyStimulus({$urandom(), $urandom()}, 1'b0, 4'd8, "t6");
    #2;
    reset = 1'b1;
    #1;
    checkValue("t6.rstValid", 64'(bus.o_out_valid), 64'd0);
    checkValue("t6.rstReady", 64'(bus.o_in_ready), 64'd0);
    checkValue("t6.rstOut", 64'(|bus.o_out), 64'd0);
    checkValue("t6.rstLast", 64'(bus.o_out_last), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    startMessage(2'b10);
    v = {$urandom(), $urandom()};
    e.data = '0; e.data[63:0] = v; e.data[71:64] = 8'h06;
    e.data[1087:1080] = 8'h80; e.last = 1'b1;
    sb.push_back(e);
    applyStimulus(v, 1'b1, 4'd8, "t6");
    checkOutput("t6", 1'b1);

    // 7: byte_num above W/8 behaves as a full word
    startMessage(2'b01);
    v = {$urandom(), $urandom()};
    e.data = '0; e.data[63:0] = v; e.data[71:64] = 8'h1F;
    e.data[1087:1080] = 8'h80; e.last = 1'b1;
    sb.push_back(e);
    applyStimulus(v, 1'b1, 4'd15, "t7");
    checkOutput("t7", 1'b1);
    @(negedge clk);
    checkValue("t7.done", 64'(bus.o_done), 64'd1);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end
endmodule
